// File: rtl/led_pkg.sv
// Shared constants and types for the LED digit sequencer.
// BLANK turns every LED off; the buffer holds DEPTH 4-bit digits.
package led_pkg;

    localparam logic [3:0] BLANK = 4'hF;
    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Lengths above the buffer depth are limited to the depth.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'(DEPTH)) ? 5'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/digit_buffer.sv
// 16x4 digit store: one synchronous write port, one combinational read port.
// Reset fills every entry with BLANK.
module digit_buffer
    import led_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= BLANK;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/led_sequencer.sv
// Plays a stored digit sequence: each digit is shown for ON_TICKS cycles,
// followed by an OFF_TICKS blank gap. All outputs are registered.
module led_sequencer
    import led_pkg::*;
#(
    parameter int ON_TICKS  = 25000000,
    parameter int OFF_TICKS = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [4:0] length,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] number,
    output logic [3:0] step,
    output logic       busy,
    output logic       done
);

    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CW = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] ON_LD  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_LD = CW'(OFF_TICKS - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] step_n;
    logic [4:0]    len, len_n;
    logic [3:0]    number_n;
    logic          busy_n, done_n;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic          last;

    digit_buffer u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && (state == IDLE)),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Read ahead: the digit for the next SHOW is fetched one cycle early.
    assign rd_addr = (state == GAP) ? step + AW'(1) : '0;
    assign last = ({1'b0, step} == len - 5'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            step   <= '0;
            len    <= '0;
            number <= BLANK;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            step   <= step_n;
            len    <= len_n;
            number <= number_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        step_n   = step;
        len_n    = len;
        number_n = number;
        busy_n   = busy;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                number_n = BLANK;
                busy_n   = 1'b0;
                if (start && (length != 5'd0)) begin
                    state_n  = SHOW;
                    cnt_n    = ON_LD;
                    step_n   = '0;
                    len_n    = clamp_len(length);
                    number_n = rd_data;
                    busy_n   = 1'b1;
                end
            end
            SHOW: begin
                if (abort) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    number_n = BLANK;
                    busy_n   = 1'b0;
                end else if (cnt == '0) begin
                    state_n  = GAP;
                    cnt_n    = OFF_LD;
                    number_n = BLANK;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    number_n = BLANK;
                    busy_n   = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (last) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    number_n = BLANK;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end else begin
                    state_n  = SHOW;
                    cnt_n    = ON_LD;
                    step_n   = step + AW'(1);
                    number_n = rd_data;
                end
            end
            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                number_n = BLANK;
                busy_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer with ON_TICKS=3, OFF_TICKS=2.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_led_sequencer;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PER = ON + OFF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [4:0] length = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] number;
    logic [3:0] step;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [3:0] num;
        logic [3:0] stp;
        bit         cs;
        logic       bsy;
        logic       dn;
        int         id;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] digs [16];

    led_sequencer #(
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .length  (length),
        .start   (start),
        .abort   (abort),
        .number  (number),
        .step    (step),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input exp_t e);
        checks++;
        if (number !== e.num || busy !== e.bsy || done !== e.dn ||
            (e.cs && step !== e.stp)) begin
            failures++;
            $display("FAIL chk%0d cyc=%0d got num=%h step=%0d busy=%b done=%b want num=%h step=%0d busy=%b done=%b",
                     e.id, cyc, number, step, busy, done,
                     e.num, e.stp, e.bsy, e.dn);
        end
    endtask

    task automatic push(input int c, input logic [3:0] n,
                        input logic [3:0] s, input bit cs,
                        input logic b, input logic d, input int id);
        exp_t e;
        e.c = c; e.num = n; e.stp = s; e.cs = cs;
        e.bsy = b; e.dn = d; e.id = id;
        sb.push_back(e);
    endtask

    // Expected trace of a playback started (start sampled) in cycle t0.
    task automatic exp_play(input int t0, input int len,
                            input int lim, input int id);
        int last_r;
        last_r = PER * len + 1;
        if (lim < last_r) last_r = lim;
        for (int r = 1; r <= last_r; r++) begin
            if (r <= PER * len) begin
                int s, ph;
                s = (r - 1) / PER;
                ph = (r - 1) % PER;
                push(t0 + r, (ph < ON) ? digs[s] : 4'hF,
                     4'(s), 1'b1, 1'b1, 1'b0, id);
            end else begin
                push(t0 + r, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, id);
            end
        end
    endtask

    task automatic exp_idle(input int c0, input int n, input int id);
        for (int i = 0; i < n; i++) begin
            push(c0 + i, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, id);
        end
    endtask

    task automatic run_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] len);
        length = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set379();
        for (int i = 0; i < 16; i++) digs[i] = 4'hF;
        digs[0] = 4'd3; digs[1] = 4'd7; digs[2] = 4'd9;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() != 0 && sb[0].c <= cyc) begin
                e = sb.pop_front();
                if (e.c != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL chk%0d stale entry cyc=%0d want cyc=%0d",
                             e.id, cyc, e.c);
                end else begin
                    cmp(e);
                end
            end
        end
    end

    initial begin : stim
        int t0, t1;
        exp_t r;

        #1 reset = 1'b1;
        #1;
        r.c = 0; r.num = 4'hF; r.stp = 4'h0; r.cs = 1'b1;
        r.bsy = 1'b0; r.dn = 1'b0; r.id = 0;
        cmp(r);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        push(t0 + 1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1);
        push(t0 + 2, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1);
        run_until(t0 + 3);

        // basic three-digit playback
        wr(4'd0, 4'd3); wr(4'd1, 4'd7); wr(4'd2, 4'd9);
        set379();
        t0 = cyc;
        exp_play(t0, 3, 99, 10);
        exp_idle(t0 + 17, 2, 11);
        go(5'd3);
        run_until(t0 + 19);

        // zero length is ignored
        t0 = cyc;
        exp_idle(t0 + 1, 4, 20);
        go(5'd0);
        run_until(t0 + 5);

        // abort mid-show, then replay from step 0
        t0 = cyc;
        exp_play(t0, 3, 7, 30);
        exp_idle(t0 + 8, 3, 31);
        go(5'd3);
        run_until(t0 + 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        run_until(t0 + 11);
        t0 = cyc;
        exp_play(t0, 3, 99, 32);
        go(5'd3);
        run_until(t0 + 17);

        // writes while busy are dropped
        t0 = cyc;
        exp_play(t0, 3, 99, 40);
        go(5'd3);
        wr(4'd1, 4'd2);
        run_until(t0 + 17);
        t0 = cyc;
        exp_play(t0, 3, 99, 41);
        go(5'd3);
        run_until(t0 + 17);

        // start while busy ignored; start on done cycle accepted
        t0 = cyc;
        exp_play(t0, 3, 99, 50);
        go(5'd3);
        run_until(t0 + 4);
        length = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_until(t0 + 16);
        t1 = cyc;
        exp_play(t1, 1, 99, 51);
        abort = 1'b1;
        go(5'd1);
        abort = 1'b0;
        run_until(t1 + 8);

        // stored values above 9 pass through unchanged
        wr(4'd0, 4'd10); wr(4'd1, 4'd14);
        digs[0] = 4'd10; digs[1] = 4'd14;
        t0 = cyc;
        exp_play(t0, 2, 99, 60);
        go(5'd2);
        run_until(t0 + 12);

        // length above depth is clamped to 16
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 4'd5);
            digs[i] = 4'd5;
        end
        t0 = cyc;
        exp_play(t0, 16, 99, 70);
        exp_idle(t0 + 82, 2, 71);
        go(5'd20);
        run_until(t0 + 84);

        // asynchronous reset in a gap, then replay a blank buffer
        t0 = cyc;
        exp_play(t0, 3, 4, 80);
        go(5'd3);
        run_until(t0 + 4);
        #2 reset = 1'b1;
        #1;
        r.c = cyc; r.num = 4'hF; r.stp = 4'h0; r.cs = 1'b1;
        r.bsy = 1'b0; r.dn = 1'b0; r.id = 81;
        cmp(r);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) digs[i] = 4'hF;
        t0 = cyc;
        exp_play(t0, 3, 99, 82);
        go(5'd3);
        run_until(t0 + 17);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter ON_TICKS, default 25000000, clock cycles each digit is shown.
REQ-002 Parameter OFF_TICKS, default 12500000, clock cycles of blank gap after each digit.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wr_en  in  1  write strobe into the 16-entry digit buffer.
REQ-006 wr_addr  in  4  buffer write index.
REQ-007 wr_data  in  4  digit to store (0-9 meaningful).
REQ-008 length  in  5  number of digits to play; sampled on accepted start.
REQ-009 start  in  1  single-cycle request to begin playback.
REQ-010 abort  in  1  single-cycle request to stop playback.
REQ-011 number  out  4  digit to the one-hot LED decoder; 4'hF = BLANK (all LEDs off).
REQ-012 step  out  4  index of the digit currently playing.
REQ-013 busy  out  1  high while a sequence is playing.
REQ-014 done  out  1  one-cycle pulse on normal completion.

Function
REQ-015 The FSM SHALL have states IDLE, SHOW and GAP.
REQ-016 In IDLE, number SHALL be BLANK and busy SHALL be 0.
REQ-017 A write SHALL occur when wr_en=1 and state is IDLE; writes while busy SHALL be ignored.
REQ-018 start SHALL be accepted only in IDLE with length != 0; otherwise it SHALL be ignored.
REQ-019 length > 16 SHALL be clamped to 16 when latched.
REQ-020 On an accepted start at cycle t, the block SHALL enter SHOW at t+1 with step=0, number=buf[0], busy=1.
REQ-021 SHOW SHALL last exactly ON_TICKS cycles with number=buf[step]; it SHALL then move to GAP.
REQ-022 GAP SHALL last exactly OFF_TICKS cycles with number=BLANK.
REQ-023 At the end of GAP, if step < latched length-1, step SHALL increment and the FSM SHALL re-enter SHOW.
REQ-024 At the end of GAP of the last step, the FSM SHALL return to IDLE, with done=1 and busy=0 for that first IDLE cycle.
REQ-025 A start in the same cycle done is high SHALL be accepted normally.
REQ-026 Stored values 10-15 SHALL be driven on number unchanged.
REQ-027 abort in SHOW or GAP SHALL force IDLE on the next cycle with number=BLANK, busy=0 and no done pulse.
REQ-028 abort in IDLE SHALL have no effect.
REQ-029 abort and start asserted together in IDLE SHALL be treated as start.
REQ-030 start while busy SHALL be ignored.
REQ-031 The tick counter SHALL be $clog2(max(ON_TICKS,OFF_TICKS)) bits wide and SHALL reload on every state change.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 Reset SHALL force IDLE, number=BLANK, step=0, busy=0, done=0 and tick counter=0, with no clock edge required.
REQ-034 Reset SHALL clear the digit buffer to BLANK.
REQ-035 Reset asserted mid-playback SHALL abandon the sequence with no done pulse.

Structure
REQ-036 The BLANK constant, buffer depth (16) and state encodings SHALL live in shared package led_pkg.
REQ-037 The 16x4 buffer SHALL be a sub-module, digit_buffer.
REQ-038 The FSM and tick counter SHALL remain in led_sequencer.

Verification (ON_TICKS=3, OFF_TICKS=2)
REQ-039 Load buf={3,7,9}, length=3, start at cycle 0: number=3 for cycles 1-3, F for 4-5, 7 for 6-8, F for 9-10, 9 for 11-13, F for 14-15; done=1 and busy=0 at cycle 16.
REQ-040 length=0 with start: busy stays 0, number stays F, no done.
REQ-041 length=20 with buf all 5: exactly 16 SHOW periods, then done.
REQ-042 abort at cycle 7 of REQ-039: number=F and busy=0 at cycle 8, no done; a later start replays from step 0.
REQ-043 wr_en during playback to addr 1 with data 2: the playing sequence and a subsequent replay both still show 7 at step 1.
REQ-044 Reset asserted mid-GAP without a clock edge: outputs go to reset values immediately; start after release plays a BLANK-filled buffer.
